// File: rtl/conv_iterator_if.sv
// Handshake and coordinate bundle between the convolution controller and
// the loop-nest sequencer. The controller drives en_ctrl; the sequencer
// drives everything else.
interface conv_iterator_if #(
  parameter int CW = 8
);
  logic                 en_ctrl;
  logic [CW-1:0]        out_row;
  logic [CW-1:0]        out_col;
  logic [CW-1:0]        chan;
  logic [CW-1:0]        k_row;
  logic [CW-1:0]        k_col;
  logic signed [CW:0]   in_row;
  logic signed [CW:0]   in_col;
  logic                 in_valid;
  logic                 en_sum;
  logic                 en_save;
  logic                 finish;

  modport master (
    output en_ctrl,
    input  out_row, out_col, chan, k_row, k_col,
    input  in_row, in_col, in_valid, en_sum, en_save, finish
  );

  modport slave (
    input  en_ctrl,
    output out_row, out_col, chan, k_row, k_col,
    output in_row, in_col, in_valid, en_sum, en_save, finish
  );
endinterface

// File: rtl/conv_iterator.sv
// Loop-nest sequencer for the convolution datapath. Walks output pixel,
// input channel and kernel tap (k_col innermost, out_row outermost) and
// presents the input-image coordinate of every tap, with an in-bounds flag
// for zero padding. The interface instance must use the same CW.
module conv_iterator #(
  parameter int CW     = 8,
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter int K_W    = 3,
  parameter int K_H    = 3,
  parameter int CH     = 1,
  parameter int STRIDE = 1,
  parameter int PAD    = 0
) (
  input  logic          clk,
  input  logic          reset,
  conv_iterator_if.slave bus
);

  localparam int OUT_W = (IMG_W + 2 * PAD - K_W) / STRIDE + 1;
  localparam int OUT_H = (IMG_H + 2 * PAD - K_H) / STRIDE + 1;

  localparam logic [CW-1:0] K_W_LAST   = CW'(K_W - 1);
  localparam logic [CW-1:0] K_H_LAST   = CW'(K_H - 1);
  localparam logic [CW-1:0] CH_LAST    = CW'(CH - 1);
  localparam logic [CW-1:0] OUT_W_LAST = CW'(OUT_W - 1);
  localparam logic [CW-1:0] OUT_H_LAST = CW'(OUT_H - 1);

  localparam logic signed [CW:0] STRIDE_S = (CW+1)'(STRIDE);
  localparam logic signed [CW:0] PAD_S    = (CW+1)'(PAD);
  localparam logic signed [CW:0] IMG_W_S  = (CW+1)'(IMG_W);
  localparam logic signed [CW:0] IMG_H_S  = (CW+1)'(IMG_H);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] out_row, out_col, chan, k_row, k_col;
  logic [CW-1:0] out_row_nxt, out_col_nxt, chan_nxt, k_row_nxt, k_col_nxt;

  logic          tap_en;
  logic          last_kc, last_kr, last_ch, last_oc, last_or;
  logic          pix_end;
  logic          final_tap;
  logic signed [CW:0] in_row, in_col;

  assign last_kc   = (k_col   == K_W_LAST);
  assign last_kr   = (k_row   == K_H_LAST);
  assign last_ch   = (chan    == CH_LAST);
  assign last_oc   = (out_col == OUT_W_LAST);
  assign last_or   = (out_row == OUT_H_LAST);

  // A tap is consumed on every edge where the sequencer runs and is not stalled.
  assign tap_en    = (state == RUN) && bus.en_ctrl;
  assign pix_end   = tap_en && last_kc && last_kr && last_ch;
  assign final_tap = pix_end && last_oc && last_or;

  // Next-state and counter-nest advance; every counter wraps to 0 on the final tap.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    state_nxt   = state;
    out_row_nxt = out_row;
    out_col_nxt = out_col;
    chan_nxt    = chan;
    k_row_nxt   = k_row;
    k_col_nxt   = k_col;

    unique case (state)
      IDLE: begin
        if (bus.en_ctrl) state_nxt = RUN;
      end
      RUN: begin
        if (tap_en) begin
          k_col_nxt = last_kc ? '0 : k_col + CW'(1);
          if (last_kc) begin
            k_row_nxt = last_kr ? '0 : k_row + CW'(1);
            if (last_kr) begin
              chan_nxt = last_ch ? '0 : chan + CW'(1);
              if (last_ch) begin
                out_col_nxt = last_oc ? '0 : out_col + CW'(1);
                if (last_oc) out_row_nxt = last_or ? '0 : out_row + CW'(1);
              end
            end
          end
          if (final_tap) state_nxt = DONE;
        end
      end
      DONE: begin
        if (!bus.en_ctrl) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and counter registers; synchronous reset aborts any run in progress.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      state   <= IDLE;
      out_row <= '0;
      out_col <= '0;
      chan    <= '0;
      k_row   <= '0;
      k_col   <= '0;
    end else begin
      state   <= state_nxt;
      out_row <= out_row_nxt;
      out_col <= out_col_nxt;
      chan    <= chan_nxt;
      k_row   <= k_row_nxt;
      k_col   <= k_col_nxt;
    end
  end

  // Input-image coordinate of the current tap; negative or past-the-edge means padding.
  assign in_row = $signed({1'b0, out_row}) * STRIDE_S + $signed({1'b0, k_row}) - PAD_S;
  assign in_col = $signed({1'b0, out_col}) * STRIDE_S + $signed({1'b0, k_col}) - PAD_S;

  assign bus.out_row  = out_row;
  assign bus.out_col  = out_col;
  assign bus.chan     = chan;
  assign bus.k_row    = k_row;
  assign bus.k_col    = k_col;
  assign bus.in_row   = in_row;
  assign bus.in_col   = in_col;
  assign bus.in_valid = !in_row[CW] && (in_row < IMG_H_S) && !in_col[CW] && (in_col < IMG_W_S);
  assign bus.en_sum   = tap_en;
  assign bus.en_save  = pix_end;
  assign bus.finish   = (state == DONE);

endmodule

// File: tb/tb_conv_iterator.sv
// Scoreboard bench for conv_iterator: four instances cover the default
// geometry, padding, stride and multi-channel accumulation. Expected taps
// are queued before each run; a negedge monitor pops one per en_sum cycle.
module tb_conv_iterator;

  typedef struct packed {
    logic [7:0] out_row;
    logic [7:0] out_col;
    logic [7:0] chan;
    logic [7:0] k_row;
    logic [7:0] k_col;
    logic [8:0] in_row;
    logic [8:0] in_col;
    logic       in_valid;
    logic       en_save;
  } tap_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] en_drv;
  int         sel;

  always #5 clk = ~clk;

  conv_iterator_if #(.CW(8)) bus0 ();
  conv_iterator_if #(.CW(8)) bus1 ();
  conv_iterator_if #(.CW(8)) bus2 ();
  conv_iterator_if #(.CW(8)) bus3 ();

  assign bus0.en_ctrl = en_drv[0];
  assign bus1.en_ctrl = en_drv[1];
  assign bus2.en_ctrl = en_drv[2];
  assign bus3.en_ctrl = en_drv[3];

  conv_iterator #(.CW(8)) u_def (.clk(clk), .reset(reset), .bus(bus0));
  conv_iterator #(.CW(8), .PAD(1)) u_pad (.clk(clk), .reset(reset), .bus(bus1));
  conv_iterator #(.CW(8), .IMG_W(5), .IMG_H(5), .STRIDE(2)) u_str (.clk(clk), .reset(reset), .bus(bus2));
  conv_iterator #(.CW(8), .CH(2)) u_ch2 (.clk(clk), .reset(reset), .bus(bus3));

  tap_t obs;
  logic o_sum, o_fin;

  // Observe whichever instance is currently under test.
  always_comb begin
    obs   = '0;
    o_sum = 1'b0;
    o_fin = 1'b0;
    case (sel)
      0: begin
        obs   = {bus0.out_row, bus0.out_col, bus0.chan, bus0.k_row, bus0.k_col,
                 bus0.in_row, bus0.in_col, bus0.in_valid, bus0.en_save};
        o_sum = bus0.en_sum;
        o_fin = bus0.finish;
      end
      1: begin
        obs   = {bus1.out_row, bus1.out_col, bus1.chan, bus1.k_row, bus1.k_col,
                 bus1.in_row, bus1.in_col, bus1.in_valid, bus1.en_save};
        o_sum = bus1.en_sum;
        o_fin = bus1.finish;
      end
      2: begin
        obs   = {bus2.out_row, bus2.out_col, bus2.chan, bus2.k_row, bus2.k_col,
                 bus2.in_row, bus2.in_col, bus2.in_valid, bus2.en_save};
        o_sum = bus2.en_sum;
        o_fin = bus2.finish;
      end
      default: begin
        obs   = {bus3.out_row, bus3.out_col, bus3.chan, bus3.k_row, bus3.k_col,
                 bus3.in_row, bus3.in_col, bus3.in_valid, bus3.en_save};
        o_sum = bus3.en_sum;
        o_fin = bus3.finish;
      end
    endcase
  end

  tap_t exp_q[$];
  tap_t mon_e;
  int   checks     = 0;
  int   errors     = 0;
  int   taps_seen  = 0;
  int   saves_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every consumed tap must match the head of the expected queue.
  always @(negedge clk) begin
    if (o_sum === 1'b1) begin
      taps_seen++;
      if (obs.en_save) saves_seen++;
      if (exp_q.size() == 0) begin
        check("tap_unexpected", 64'(taps_seen), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("tap%0d_sel%0d", taps_seen, sel), 64'(obs), 64'(mon_e));
      end
    end
  end

  // Queue the full tap stream of one run, iterating the loop nest directly.
  task automatic push_run(input int iw, input int ih, input int kw, input int kh,
                          input int ch, input int s, input int p);
    int   ow, oh, ir, ic;
    tap_t e;
    ow = (iw + 2 * p - kw) / s + 1;
    oh = (ih + 2 * p - kh) / s + 1;
    for (int orow = 0; orow < oh; orow++)
      for (int ocol = 0; ocol < ow; ocol++)
        for (int c = 0; c < ch; c++)
          for (int kr = 0; kr < kh; kr++)
            for (int kc = 0; kc < kw; kc++) begin
              ir = orow * s + kr - p;
              ic = ocol * s + kc - p;
              e.out_row  = 8'(orow);
              e.out_col  = 8'(ocol);
              e.chan     = 8'(c);
              e.k_row    = 8'(kr);
              e.k_col    = 8'(kc);
              e.in_row   = 9'(ir);
              e.in_col   = 9'(ic);
              e.in_valid = (ir >= 0) && (ir < ih) && (ic >= 0) && (ic < iw);
              e.en_save  = (kc == kw - 1) && (kr == kh - 1) && (c == ch - 1);
              exp_q.push_back(e);
            end
  endtask

  // Hand-computed spot values at specific taps.
  task automatic spot(input int s, input int t);
    if (s == 0 && t == 9)  check("def_t9_save", 64'(obs.en_save), 64'(1));
    if (s == 0 && t == 10) begin
      check("def_t10_ocol", 64'(obs.out_col), 64'(1));
      check("def_t10_inrow", 64'(obs.in_row), 64'(0));
      check("def_t10_incol", 64'(obs.in_col), 64'(1));
    end
    if (s == 1 && t == 1) begin
      check("pad_t1_inrow", 64'(obs.in_row), 64'(9'h1FF));
      check("pad_t1_incol", 64'(obs.in_col), 64'(9'h1FF));
      check("pad_t1_valid", 64'(obs.in_valid), 64'(0));
    end
    if (s == 1 && t == 5) begin
      check("pad_t5_inrow", 64'(obs.in_row), 64'(0));
      check("pad_t5_incol", 64'(obs.in_col), 64'(0));
      check("pad_t5_valid", 64'(obs.in_valid), 64'(1));
    end
    if (s == 1 && t == 144) begin
      check("pad_last_inrow", 64'(obs.in_row), 64'(4));
      check("pad_last_incol", 64'(obs.in_col), 64'(4));
      check("pad_last_valid", 64'(obs.in_valid), 64'(0));
    end
    if (s == 2 && t == 10) check("str_px01_incol", 64'(obs.in_col), 64'(2));
    if (s == 2 && t == 36) begin
      check("str_last_inrow", 64'(obs.in_row), 64'(4));
      check("str_last_incol", 64'(obs.in_col), 64'(4));
    end
    if (s == 3 && t == 9)  check("ch2_t9_save", 64'(obs.en_save), 64'(0));
    if (s == 3 && t == 10) check("ch2_t10_chan", 64'(obs.chan), 64'(1));
    if (s == 3 && t == 18) check("ch2_t18_save", 64'(obs.en_save), 64'(1));
    if (s == 3 && t == 19) check("ch2_t19_chan", 64'(obs.chan), 64'(0));
  endtask

  // One run of instance s from IDLE: optional 3-cycle stall after tap
  // stall_at, optional reset abort after tap abort_at, then DONE release.
  task automatic run_dut(input int s, input int n, input int n_saves,
                         input int stall_at, input int abort_at);
    int   t0, s0;
    tap_t e;
    t0 = taps_seen;
    s0 = saves_seen;
    @(posedge clk); #1 en_drv[s] = 1'b1;
    @(negedge clk);
    check("idle_no_tap", 64'(o_sum), 64'(0));
    @(posedge clk);
    for (int t = 1; t <= n; t++) begin
      @(negedge clk);
      spot(s, t);
      @(posedge clk);
      if (t == abort_at) begin
        #1 reset = 1'b1;
        en_drv[s] = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("abort_counters", 64'({obs.out_row, obs.out_col, obs.chan, obs.k_row, obs.k_col}), 64'(0));
        check("abort_finish", 64'(o_fin), 64'(0));
        check("abort_sum", 64'(o_sum), 64'(0));
        check("abort_taps", 64'(taps_seen - t0), 64'(abort_at));
        check("abort_saves", 64'(saves_seen - s0), 64'(n_saves * abort_at / n));
        exp_q.delete();
        return;
      end
      if (t == stall_at) begin
        #1 en_drv[s] = 1'b0;
        repeat (3) begin
          @(negedge clk);
          e = exp_q[0];
          e.en_save = 1'b0;
          check("stall_sum", 64'(o_sum), 64'(0));
          check("stall_hold", 64'(obs), 64'(e));
          @(posedge clk);
        end
        #1 en_drv[s] = 1'b1;
      end
    end
    @(negedge clk);
    check("done_finish", 64'(o_fin), 64'(1));
    check("done_sum", 64'(o_sum), 64'(0));
    check("done_counters", 64'({obs.out_row, obs.out_col, obs.chan, obs.k_row, obs.k_col}), 64'(0));
    repeat (4) begin
      @(negedge clk);
      check("done_hold", 64'(o_fin), 64'(1));
    end
    @(posedge clk); #1 en_drv[s] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("release_finish", 64'(o_fin), 64'(0));
    check("release_sum", 64'(o_sum), 64'(0));
    check("run_taps", 64'(taps_seen - t0), 64'(n));
    check("run_saves", 64'(saves_seen - s0), 64'(n_saves));
    check("run_queue_left", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    sel    = 0;
    en_drv = '0;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_finish", 64'(o_fin), 64'(0));
    check("rst_sum", 64'(o_sum), 64'(0));
    check("rst_save", 64'(obs.en_save), 64'(0));
    check("rst_counters", 64'({obs.out_row, obs.out_col, obs.chan, obs.k_row, obs.k_col}), 64'(0));
    check("rst_inrow_def", 64'(obs.in_row), 64'(0));
    sel = 1;
    #1;
    check("rst_inrow_pad", 64'(obs.in_row), 64'(9'h1FF));
    check("rst_incol_pad", 64'(obs.in_col), 64'(9'h1FF));
    sel = 0;

    // Defaults with a stall after tap 5, then an identical restart, then an abort.
    push_run(4, 4, 3, 3, 1, 1, 0);
    run_dut(0, 36, 4, 5, 0);
    push_run(4, 4, 3, 3, 1, 1, 0);
    run_dut(0, 36, 4, 0, 0);
    push_run(4, 4, 3, 3, 1, 1, 0);
    run_dut(0, 36, 4, 0, 20);

    sel = 1;
    push_run(4, 4, 3, 3, 1, 1, 1);
    run_dut(1, 144, 16, 0, 0);

    sel = 2;
    push_run(5, 5, 3, 3, 1, 2, 0);
    run_dut(2, 36, 4, 0, 0);

    sel = 3;
    push_run(4, 4, 3, 3, 2, 1, 0);
    run_dut(3, 72, 4, 0, 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
